// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: word width, FSM states and
// parameter defaults.
package mem_pkg;

    localparam int WORD_W      = 64;
    localparam int DEPTH_DEF   = 256;
    localparam int LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_responder: synchronous write, combinational read.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset, so contents survive rst_n and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, commits the access and holds the response until it is taken.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         AW       = addr_w(DEPTH);
    localparam bit         LAT_ONE  = (LATENCY == 1);
    localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_write;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_commit;
    logic              w_op_write;
    logic [WORD_W-1:0] w_op_addr;
    logic [WORD_W-1:0] w_op_wdata;
    logic              w_in_range;
    logic [AW-1:0]     w_idx;
    logic              w_we;
    logic [WORD_W-1:0] w_rd_data;
    logic [WORD_W-1:0] w_rsp_rdata;

    assign w_accept = req_valid && (r_state == IDLE);

    // With LATENCY=1 the commit edge is the accept edge, so the operation
    // comes straight from the request inputs instead of the latched copy.
    assign w_op_write = LAT_ONE ? req_write : r_write;
    assign w_op_addr  = LAT_ONE ? req_addr  : r_addr;
    assign w_op_wdata = LAT_ONE ? req_wdata : r_wdata;
    assign w_commit   = LAT_ONE ? w_accept  : ((r_state == WAIT) && (r_cnt == 3'd0));

    assign w_in_range  = (w_op_addr < WORD_W'(DEPTH));
    assign w_idx       = w_in_range ? w_op_addr[AW-1:0] : '0;
    assign w_we        = w_commit && w_op_write && w_in_range;
    assign w_rsp_rdata = (w_op_write || !w_in_range) ? '0 : w_rd_data;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (w_op_wdata),
        .o_rdata (w_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (LAT_ONE) begin
                            r_state     <= RESP;
                            r_rsp_rdata <= w_rsp_rdata;
                            r_rsp_err   <= !w_in_range;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state     <= RESP;
                        r_rsp_rdata <= w_rsp_rdata;
                        r_rsp_err   <= !w_in_range;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 64-bit words stored (word-addressed).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request accept to rsp_valid; the legal range is 1..7.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, width 1: one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, width 1: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, width 1: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_write, input, width 1: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, width 64: the word address.
REQ-009 The block SHALL have port req_wdata, input, width 64: the write data.
REQ-010 The block SHALL have port rsp_valid, output, width 1: a response is present.
REQ-011 The block SHALL have port rsp_ready, input, width 1: the initiator takes the response.
REQ-012 The block SHALL have port rsp_rdata, output, width 64: the read data (0 for writes and errors).
REQ-013 The block SHALL have port rsp_err, output, width 1: the address was out of range (req_addr >= DEPTH).
REQ-014 The block SHALL have port busy, output, width 1: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP. req_ready SHALL be high only in IDLE, and rsp_valid SHALL be high only in RESP.
REQ-016 A request SHALL be accepted at the rising edge where req_valid and req_ready are both high. At that edge the block SHALL latch req_write, req_addr and req_wdata; the request inputs SHALL be ignored at all other times.
REQ-017 On accept, the FSM SHALL go to RESP if LATENCY = 1, and otherwise to WAIT, with a down-counter loaded to LATENCY-2.
REQ-018 In WAIT, the FSM SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0. rsp_valid SHALL therefore rise exactly LATENCY cycles after the accept edge.
REQ-019 The memory operation SHALL be committed on the edge that enters RESP:
- write, in range: mem[addr] <= wdata.
- read, in range: rsp_rdata <= mem[addr].
- out of range: no write, rsp_rdata <= 0, rsp_err <= 1.
REQ-020 The range check SHALL use the full 64-bit address; there SHALL be no wrap-around or truncation, so address DEPTH and address 2^64-1 are both errors.
REQ-021 rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0; a stall of any length SHALL be allowed.
REQ-022 In RESP, when rsp_ready=1, the FSM SHALL go to IDLE and rsp_valid SHALL fall on that edge. req_ready SHALL rise in the same cycle, so the earliest next accept is one cycle after the response handshake.
REQ-023 A read issued after a write to the same address SHALL return the new data; a write followed by a read of that address SHALL never return stale data.
REQ-024 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL force: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, and latched request fields=0. req_ready SHALL be 1 from the first cycle after reset.
REQ-026 Reset during WAIT SHALL abort the operation, and an uncommitted write SHALL NOT modify memory. Reset during RESP SHALL drop the response.
REQ-027 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-028 A shared package mem_pkg SHALL hold: the word width (64), the state enum (IDLE/WAIT/RESP), and the DEPTH and LATENCY defaults.
REQ-029 Storage SHALL be a single sub-module mem_array with synchronous write, combinational read, and DEPTH x 64 bits, instantiated once in mem_responder.
REQ-030 The FSM, the latency counter and the response registers SHALL reside in mem_responder.

Verification
REQ-031 Write then read, LATENCY=2: write addr 5, data 0x1234 with rsp_ready=1; then read addr 5. The required response is rsp_valid exactly 2 cycles after each accept, the read returns rsp_rdata=0x1234 with rsp_err=0, and the write response has rsp_rdata=0.
REQ-032 Out of range, DEPTH=256: write addr 256, data 0xFF, then read addr 256, and read addr 0xFFFF_FFFF_FFFF_FFFF. The required response is rsp_err=1 and rsp_rdata=0 for each, with the in-range contents unchanged.
REQ-033 Backpressure: hold rsp_ready=0 for 5 cycles during a read of addr 3 after writing 0xAB there. The required response is rsp_valid held and rsp_rdata=0xAB stable, req_ready=0 throughout, and req_ready=1 the cycle after the handshake.
REQ-034 Latency sweep: run LATENCY=1, 4 and 7 with a single read each. The required response is rsp_valid rising exactly 1, 4 and 7 cycles after accept, with busy high from the accept edge until the response handshake.
REQ-035 Reset mid-write: with addr 9 holding 0x55, accept a write of 0x99 to addr 9 with LATENCY=4 and assert rst_n=0 two cycles later. The required response is that outputs reach their reset values and a subsequent read of addr 9 returns 0x55.
REQ-036 Back-to-back traffic: keep req_valid=1 with alternating write and read to addr 0 and rsp_ready tied to 1. The required response is at most one outstanding request, each read returning the preceding write data, and no accept while busy.
